uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FQC, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter RX_BAUD, default 9600, line baud rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (8 or 16).
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-005 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-007 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of 2, >=2).
REQ-008 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-009 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-010 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-011 SHALL have port m_data  output  DATA_BITS  FIFO head data.
REQ-012 SHALL have port m_perr  output  1  parity error flag of head entry.
REQ-013 SHALL have port m_ferr  output  1  framing error flag of head entry.
REQ-014 SHALL have port m_valid  output  1  FIFO not empty.
REQ-015 SHALL have port m_ready  input  1  consumer accept; pop when m_valid and m_ready.
REQ-016 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  entries stored.
REQ-017 SHALL have port overflow  output  1  one-cycle pulse when a frame is dropped.
REQ-018 SHALL have port busy  output  1  high while the FSM is not IDLE.

Function
REQ-019 SHALL synchronise rx through two flops (reset value 1) before any use.
REQ-020 SHALL generate a sample tick every DIV = round(CLK_FQC/(RX_BAUD*OVERSAMPLE)) clocks; the counter restarts on start-edge detection.
REQ-021 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-022 SHALL leave IDLE on a synchronised 1->0 transition and decide each bit by 2-of-3 majority of the samples at ticks OVERSAMPLE/2-1, /2, /2+1.
REQ-023 SHALL return from START to IDLE without pushing if the start-bit majority is 1 (glitch rejection).
REQ-024 SHALL shift DATA_BITS bits LSB first.
REQ-025 SHALL set perr when received parity mismatches the even/odd parity of the data bits; perr=0 when PARITY=0.
REQ-026 SHALL set ferr when any checked stop-bit majority is 0.
REQ-027 SHALL push {ferr, perr, data} into the FIFO in the cycle following the last stop-bit decision and return to IDLE immediately, accepting a new start edge from the next clock.
REQ-028 SHALL present FIFO head combinationally on m_data/m_perr/m_ferr (show-ahead); outputs are don't-care while m_valid=0.
REQ-029 SHALL, when full and no pop, drop the new frame, keep contents, and pulse overflow for one clock.
REQ-030 SHALL, on simultaneous push and pop when full, accept both; fifo_count unchanged, no overflow.
REQ-031 SHALL, on simultaneous push and pop when empty, perform the push only; pop is ignored because m_valid=0.
REQ-032 SHALL wrap FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-033 SHALL on rst_n low force FSM to IDLE, FIFO empty, m_valid=0, fifo_count=0, overflow=0, busy=0, sync flops=1, tick counter=0.
REQ-034 SHALL abandon any in-progress frame on reset without pushing; after release the next complete frame is received correctly.

Structure
REQ-035 SHALL place parity-mode constants, FSM state encoding and the DIV computation function in shared package uart_pkg.
REQ-036 SHALL implement storage as sub-module sync_fifo (width DATA_BITS+2, depth FIFO_DEPTH, same clk/rst_n).

Verification (CLK_FQC=50_000_000, RX_BAUD=312_500, OVERSAMPLE=16 -> DIV=10, bit=3.2 us)
REQ-037 SHALL cover 8N1 frames 0xAF then 0x56, m_ready=0 -> fifo_count=2, head 0xAF perr=0 ferr=0; after one pop head 0x56.
REQ-038 SHALL cover PARITY=1, frame 0x03 with parity bit 1 -> entry 0x03 perr=1; with parity bit 0 -> perr=0.
REQ-039 SHALL cover stop bit driven 0 on frame 0x55 -> entry 0x55 ferr=1; following valid frame 0x12 -> ferr=0.
REQ-040 SHALL cover 200 ns low glitch on idle rx -> busy pulses then returns low, fifo_count stays 0.
REQ-041 SHALL cover 17 frames 0x00..0x10 with m_ready=0 and FIFO_DEPTH=16 -> fifo_count=16, one overflow pulse, draining yields 0x00..0x0F only.
REQ-042 SHALL cover rst_n low mid-DATA of frame 0xA5 -> all outputs at reset values, no entry; next frame 0x3C received as 0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: parity modes, FSM state encoding and
// the sample-tick divider computation.
`timescale 1ns/1ps
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Clocks per sample tick, rounded to nearest: CLK_FQC / (RX_BAUD * OVERSAMPLE)
    function automatic int calc_div(input int clk_fqc, input int baud, input int os);
        longint den;
        den = longint'(baud) * longint'(os);
        return int'((longint'(clk_fqc) + den / 2) / den);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; pop is ignored when empty, and a push while
// full is accepted only if a pop happens in the same cycle.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (!do_wr && do_rd) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit decisions, optional
// parity, 1 or 2 checked stop bits, feeding a show-ahead receive FIFO.
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FQC    = 50_000_000,
    parameter int RX_BAUD    = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_perr,
    output logic                          m_ferr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy
);

    localparam int DIV   = calc_div(CLK_FQC, RX_BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int EW    = DATA_BITS + 2;

    localparam logic [OS_W-1:0]  SMP0      = OS_W'(OVERSAMPLE/2 - 1);
    localparam logic [OS_W-1:0]  SMP1      = OS_W'(OVERSAMPLE/2);
    localparam logic [OS_W-1:0]  SMP2      = OS_W'(OVERSAMPLE/2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    logic                 rx_m, rx_s, rx_d;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic                 start_edge;
    rx_state_t            state;
    logic [OS_W-1:0]      os_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [1:0]           smp;
    logic                 maj;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr_acc;
    logic                 perr_calc;
    logic                 push_q;
    logic [EW-1:0]        push_data;
    logic [EW-1:0]        head;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign start_edge = (state == ST_IDLE) && rx_d && !rx_s;
    assign tick       = (div_cnt == DIV_W'(DIV - 1));
    assign maj        = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

    always_comb begin
        perr_calc = 1'b0;
        if (PARITY == PAR_EVEN)     perr_calc = (^shreg) ^ par_bit;
        else if (PARITY == PAR_ODD) perr_calc = ~((^shreg) ^ par_bit);
    end

    // Sample-tick divider, realigned to the detected start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (start_edge || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Receive FSM: bits are decided at the third mid-bit sample; the final
    // stop bit decision returns to IDLE at once so back-to-back frames fit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            os_cnt    <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            smp       <= 2'b11;
            shreg     <= '0;
            par_bit   <= 1'b0;
            ferr_acc  <= 1'b0;
            push_q    <= 1'b0;
            push_data <= '0;
        end else begin
            push_q <= 1'b0;
            if (state == ST_IDLE) begin
                if (start_edge) begin
                    state    <= ST_START;
                    busy     <= 1'b1;
                    os_cnt   <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    ferr_acc <= 1'b0;
                end
            end else if (tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
                if (os_cnt == SMP0) smp[0] <= rx_s;
                if (os_cnt == SMP1) smp[1] <= rx_s;
                if (os_cnt == SMP2) begin
                    case (state)
                        ST_START: begin
                            if (maj) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                        ST_DATA:   shreg   <= {maj, shreg[DATA_BITS-1:1]};
                        ST_PARITY: par_bit <= maj;
                        ST_STOP: begin
                            if (stop_idx == STOP_LAST) begin
                                push_q    <= 1'b1;
                                push_data <= {ferr_acc | ~maj, perr_calc, shreg};
                                state     <= ST_IDLE;
                                busy      <= 1'b0;
                            end else begin
                                ferr_acc <= ferr_acc | ~maj;
                            end
                        end
                        default: ;
                    endcase
                end
                if (os_cnt == OS_LAST) begin
                    case (state)
                        ST_START: state <= ST_DATA;
                        ST_DATA: begin
                            if (bit_idx == DATA_LAST) begin
                                state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                        ST_PARITY: state    <= ST_STOP;
                        ST_STOP:   stop_idx <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Overflow pulses when a completed frame finds the FIFO full with no pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= push_q && fifo_full && !(m_ready && !fifo_empty);
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_q),
        .wr_data (push_data),
        .rd_en   (m_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = head[DATA_BITS-1:0];
    assign m_perr  = head[DATA_BITS];
    assign m_ferr  = head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 312.5 kBaud from a 50 MHz clock.
// Instance 0 is 8N1, instance 1 is 8E1; both share clock and reset.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int BIT_NS = 3200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic       m_ready0 = 1'b0;
    logic       m_ready1 = 1'b0;
    logic [7:0] m_data0, m_data1;
    logic       m_perr0, m_perr1, m_ferr0, m_ferr1;
    logic       m_valid0, m_valid1;
    logic [4:0] fifo_count0, fifo_count1;
    logic       overflow0, overflow1;
    logic       busy0, busy1;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    int ovf_base;

    always #10 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FQC    (50_000_000),
        .RX_BAUD    (312_500),
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .PARITY     (0),
        .STOP_BITS  (1),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx0),
        .m_data     (m_data0),
        .m_perr     (m_perr0),
        .m_ferr     (m_ferr0),
        .m_valid    (m_valid0),
        .m_ready    (m_ready0),
        .fifo_count (fifo_count0),
        .overflow   (overflow0),
        .busy       (busy0)
    );

    uart_rx_fifo #(
        .CLK_FQC    (50_000_000),
        .RX_BAUD    (312_500),
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .PARITY     (1),
        .STOP_BITS  (1),
        .FIFO_DEPTH (16)
    ) dut_par (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx1),
        .m_data     (m_data1),
        .m_perr     (m_perr1),
        .m_ferr     (m_ferr1),
        .m_valid    (m_valid1),
        .m_ready    (m_ready1),
        .fifo_count (fifo_count1),
        .overflow   (overflow1),
        .busy       (busy1)
    );

    // Running count of overflow pulses seen on instance 0
    always @(negedge clk) begin
        if (overflow0) ovf_cnt = ovf_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic stop_val);
        set_rx(sel, 1'b0);
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            #BIT_NS;
        end
        if (has_par) begin
            set_rx(sel, pbit);
            #BIT_NS;
        end
        set_rx(sel, stop_val);
        #BIT_NS;
        set_rx(sel, 1'b1);
        #BIT_NS;
    endtask

    task automatic pop(input int sel);
        @(negedge clk);
        if (sel == 0) m_ready0 = 1'b1;
        else          m_ready1 = 1'b1;
        @(negedge clk);
        m_ready0 = 1'b0;
        m_ready1 = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(m_valid0), 32'd0);
        chk("rst_count", 32'(fifo_count0), 32'd0);
        chk("rst_ovf",   32'(overflow0), 32'd0);
        chk("rst_busy",  32'(busy0), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Two 8N1 frames held in the FIFO
        send_frame(0, 8'hAF, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h56, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("8n1_count", 32'(fifo_count0), 32'd2);
        chk("8n1_valid", 32'(m_valid0), 32'd1);
        chk("8n1_head0", 32'(m_data0), 32'hAF);
        chk("8n1_perr0", 32'(m_perr0), 32'd0);
        chk("8n1_ferr0", 32'(m_ferr0), 32'd0);
        pop(0);
        chk("8n1_head1", 32'(m_data0), 32'h56);
        chk("8n1_count1", 32'(fifo_count0), 32'd1);
        pop(0);
        chk("8n1_empty", 32'(m_valid0), 32'd0);

        // Even parity: 0x03 has even ones, so parity bit 1 is an error
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("par_count", 32'(fifo_count1), 32'd2);
        chk("par_data0", 32'(m_data1), 32'h03);
        chk("par_perr0", 32'(m_perr1), 32'd1);
        chk("par_ferr0", 32'(m_ferr1), 32'd0);
        pop(1);
        chk("par_data1", 32'(m_data1), 32'h03);
        chk("par_perr1", 32'(m_perr1), 32'd0);
        pop(1);

        // Framing error on a zero stop bit, then a clean frame
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("fe_count", 32'(fifo_count0), 32'd2);
        chk("fe_data0", 32'(m_data0), 32'h55);
        chk("fe_ferr0", 32'(m_ferr0), 32'd1);
        pop(0);
        chk("fe_data1", 32'(m_data0), 32'h12);
        chk("fe_ferr1", 32'(m_ferr0), 32'd0);
        pop(0);

        // 200 ns glitch: start detected, then rejected
        @(negedge clk);
        rx0 = 1'b0;
        #200;
        rx0 = 1'b1;
        @(negedge clk);
        chk("gl_busy_hi", 32'(busy0), 32'd1);
        #BIT_NS;
        @(negedge clk);
        chk("gl_busy_lo", 32'(busy0), 32'd0);
        chk("gl_count", 32'(fifo_count0), 32'd0);

        // 17 frames into a 16-deep FIFO: last one dropped
        ovf_base = ovf_cnt;
        for (int i = 0; i < 17; i++) begin
            send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        chk("of_count", 32'(fifo_count0), 32'd16);
        chk("of_pulses", 32'(ovf_cnt - ovf_base), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("of_drain", 32'(m_data0), 32'(i));
            pop(0);
        end
        chk("of_empty", 32'(m_valid0), 32'd0);

        // Reset in the middle of frame 0xA5 with one entry stored
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        rx0 = 1'b0;
        #BIT_NS;
        rx0 = 1'b1; #BIT_NS;
        rx0 = 1'b0; #BIT_NS;
        rx0 = 1'b1; #BIT_NS;
        rx0 = 1'b0; #(BIT_NS/2);
        chk("mr_busy_pre", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        rx0 = 1'b1;
        #100;
        chk("mr_valid", 32'(m_valid0), 32'd0);
        chk("mr_count", 32'(fifo_count0), 32'd0);
        chk("mr_busy",  32'(busy0), 32'd0);
        chk("mr_ovf",   32'(overflow0), 32'd0);
        #(2*BIT_NS);
        @(negedge clk);
        rst_n = 1'b1;
        #BIT_NS;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("mr_count1", 32'(fifo_count0), 32'd1);
        chk("mr_data",   32'(m_data0), 32'h3C);
        chk("mr_perr",   32'(m_perr0), 32'd0);
        chk("mr_ferr",   32'(m_ferr0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
